io_bus_bridge: RTL and testbench

- Data-side bus stage directly downstream of the main decoder. It consumes the decoder's MemRead/MemWrite/IORead/IOWrite strobes together with the ALU address and rs2 data.
- Routes store enables to data memory, or latches them into the LED and 7-segment registers.
- Returns load data to the register-file write-back mux.
- Stalls the single-cycle core while a switch-input load waits for a debounced confirm-button press and release.

---
 rtl/io_bus_bridge_if.sv | 24 ++
 rtl/io_bus_bridge.sv | 130 +++++++++++++
 tb/tb_io_bus_bridge.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_bridge_if.sv
// Data-side bus between the decoder/ALU/data memory and io_bus_bridge.
// The bridge takes the slave modport and the core side takes the master modport.
interface io_bus_bridge_if;
  logic        mem_read;
  logic        mem_write;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;
  logic        mem_we;
  logic        stall;

  modport master (
    output mem_read, mem_write, io_read, io_write, addr, wdata, mem_rdata,
    input  rdata, mem_we, stall
  );

  modport slave (
    input  mem_read, mem_write, io_read, io_write, addr, wdata, mem_rdata,
    output rdata, mem_we, stall
  );
endinterface

// File: rtl/io_bus_bridge.sv
// Load/store routing between the core, data memory and board IO (LED, 7-seg, switches),
// with a blocking switch read that stalls the core until the confirm button is pressed and released.
module io_bus_bridge #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LED_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  io_bus_bridge_if.slave   bus,
  input  logic [LED_W-1:0] switch_in,
  input  logic             btn_confirm,
  output logic [LED_W-1:0] led,
  output logic [31:0]      seg_value
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [9:0] OFF_LED    = 10'h000;
  localparam logic [9:0] OFF_SEG    = 10'h004;
  localparam logic [9:0] OFF_SW_CNF = 10'h010;
  localparam logic [9:0] OFF_SW_RAW = 10'h014;
  localparam logic [9:0] OFF_BTN    = 10'h018;

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

  state_t           state, state_nx;
  logic [LED_W-1:0] sw_s1, sw_s2, sw_cap;
  logic             btn_s1, btn_s2, btn_db;
  logic [CW-1:0]    db_cnt;
  logic             cap_en;
  logic [9:0]       off;
  logic [31:0]      io_val;

  assign off = bus.addr[9:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= switch_in;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_confirm;
      btn_s2 <= btn_s1;
    end
  end

  // Debounced value only moves after the synchronized button disagrees for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s2 != btn_db) begin
      if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= ~btn_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= '0;
      seg_value <= '0;
    end else if (bus.io_write) begin
      if (off == OFF_LED) led       <= bus.wdata[LED_W-1:0];
      if (off == OFF_SEG) seg_value <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         if (bus.io_read && off == OFF_SW_CNF) state_nx = WAIT_PRESS;
      WAIT_PRESS:   if (btn_db)  state_nx = WAIT_RELEASE;
      WAIT_RELEASE: if (!btn_db) state_nx = DONE;
      DONE:         state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  // Stall rises in the same cycle the blocking read is decoded so the PC never advances past it.
  always_comb begin
    bus.stall = 1'b0;
    cap_en    = 1'b0;
    case (state)
      IDLE:         bus.stall = bus.io_read && off == OFF_SW_CNF;
      WAIT_PRESS: begin
        bus.stall = 1'b1;
        cap_en    = btn_db;
      end
      WAIT_RELEASE: bus.stall = 1'b1;
      default:      bus.stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         sw_cap <= '0;
    else if (cap_en) sw_cap <= sw_s2;
  end

  always_comb begin
    case (off)
      OFF_LED:    io_val = 32'(led);
      OFF_SEG:    io_val = seg_value;
      OFF_SW_CNF: io_val = 32'(sw_cap);
      OFF_SW_RAW: io_val = 32'(sw_s2);
      OFF_BTN:    io_val = {31'b0, btn_db};
      default:    io_val = '0;
    endcase
  end

  assign bus.mem_we = bus.mem_write & ~bus.io_write;

  always_comb begin
    if (bus.io_read)       bus.rdata = io_val;
    else if (bus.mem_read) bus.rdata = bus.mem_rdata;
    else                   bus.rdata = '0;
  end
endmodule

// File: tb/tb_io_bus_bridge.sv
// Randomized + directed bench for io_bus_bridge against a cycle-level reference model.
module tb_io_bus_bridge;
  localparam int DEB = 4;
  localparam int LW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] switch_in, led;
  logic          btn_confirm;
  logic [31:0]   seg_value;

  always #5 clk = ~clk;

  io_bus_bridge_if bus();

  io_bus_bridge #(.DEBOUNCE_CYCLES(DEB), .LED_W(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .switch_in(switch_in),
    .btn_confirm(btn_confirm), .led(led), .seg_value(seg_value)
  );

  logic          t_rst, t_mr, t_mw, t_ir, t_iw, t_btn;
  logic [31:0]   t_addr, t_wdata, t_mrd;
  logic [LW-1:0] t_sw;

  // reference model: registers, sync pipes, last DEB synchronized button samples, read phase
  logic [LW-1:0] m_led, m_cap, m_sw1, m_sw2;
  logic [31:0]   m_seg;
  logic          m_b1, m_b2, m_db;
  logic          hist [DEB];
  int            phase;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_led = '0; m_cap = '0; m_sw1 = '0; m_sw2 = '0; m_seg = '0;
    m_b1 = 1'b0; m_b2 = 1'b0; m_db = 1'b0; phase = 0;
    for (int i = 0; i < DEB; i++) hist[i] = 1'b0;
  endtask

  task automatic idle();
    t_rst = 1'b0; t_mr = 1'b0; t_mw = 1'b0; t_ir = 1'b0; t_iw = 1'b0;
    t_addr = '0; t_wdata = '0; t_mrd = '0;
  endtask

  task automatic step();
    logic [9:0]  off;
    logic [31:0] io_v, e_rd;
    logic        e_stall, flip;
    @(negedge clk);
    rst = t_rst; bus.mem_read = t_mr; bus.mem_write = t_mw; bus.io_read = t_ir;
    bus.io_write = t_iw; bus.addr = t_addr; bus.wdata = t_wdata; bus.mem_rdata = t_mrd;
    switch_in = t_sw; btn_confirm = t_btn;
    #1;
    off = t_addr[9:0];
    case (off)
      10'h000: io_v = 32'(m_led);
      10'h004: io_v = m_seg;
      10'h010: io_v = 32'(m_cap);
      10'h014: io_v = 32'(m_sw2);
      10'h018: io_v = {31'b0, m_db};
      default: io_v = '0;
    endcase
    e_rd    = t_ir ? io_v : (t_mr ? t_mrd : 32'h0);
    e_stall = (phase == 1) || (phase == 2) || (phase == 0 && t_ir && off == 10'h010);
    chk("rdata", bus.rdata, e_rd);
    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, t_mw & ~t_iw});
    chk("stall", {31'b0, bus.stall}, {31'b0, e_stall});
    chk("led", 32'(led), 32'(m_led));
    chk("seg", seg_value, m_seg);
    @(posedge clk);
    if (t_rst) m_reset();
    else begin
      if (t_iw && off == 10'h000) m_led = t_wdata[LW-1:0];
      if (t_iw && off == 10'h004) m_seg = t_wdata;
      case (phase)
        0: if (t_ir && off == 10'h010) phase = 1;
        1: if (m_db) begin m_cap = m_sw2; phase = 2; end
        2: if (!m_db) phase = 3;
        default: phase = 0;
      endcase
      for (int i = DEB - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_b2;
      flip = 1'b1;
      for (int i = 0; i < DEB; i++) if (hist[i] == m_db) flip = 1'b0;
      if (flip) m_db = ~m_db;
      m_b2 = m_b1; m_b1 = t_btn; m_sw2 = m_sw1; m_sw1 = t_sw;
    end
  endtask

  initial begin
    bit   done;
    logic [9:0] roff;
    rst = 1'b1; bus.mem_read = 0; bus.mem_write = 0; bus.io_read = 0; bus.io_write = 0;
    bus.addr = '0; bus.wdata = '0; bus.mem_rdata = '0; switch_in = '0; btn_confirm = 0;
    repeat (2) @(posedge clk);
    m_reset();
    idle(); t_sw = '0; t_btn = 1'b0;
    t_rst = 1'b1; step();
    t_rst = 1'b0;
    #2; chk("reset_stall", {31'b0, bus.stall}, 32'h0);
    chk("reset_led", 32'(led), 32'h0);

    // LED write then read back
    t_iw = 1; t_addr = 32'hFFFFFC00; t_wdata = 32'h0001A5A5; step();
    #2; chk("led_write", 32'(led), 32'h0000A5A5);
    idle(); t_ir = 1; t_addr = 32'hFFFFFC00; step();
    #2; chk("led_read", bus.rdata, 32'h0000A5A5);

    // memory path, IO wins when both write strobes collide
    idle(); t_mw = 1; t_addr = 32'h00000040; t_wdata = 32'h5555; step();
    #2; chk("mem_we", {31'b0, bus.mem_we}, 32'h1);
    chk("led_kept", 32'(led), 32'h0000A5A5);
    idle(); t_mr = 1; t_addr = 32'h00000040; t_mrd = 32'hDEADBEEF; step();
    #2; chk("mem_read", bus.rdata, 32'hDEADBEEF);
    idle(); t_mw = 1; t_iw = 1; t_addr = 32'hFFFFFC04; t_wdata = 32'h12345678; step();
    #2; chk("io_wins_we", {31'b0, bus.mem_we}, 32'h0);
    chk("seg_write", seg_value, 32'h12345678);

    // read-only / unmapped
    idle(); t_iw = 1; t_addr = 32'hFFFFFC10; t_wdata = 32'hFFFFFFFF; step();
    idle(); t_ir = 1; t_addr = 32'hFFFFFFFC; step();
    #2; chk("unmapped_read", bus.rdata, 32'h0);
    chk("ro_write_seg", seg_value, 32'h12345678);

    // blocking read with a glitch first
    idle(); t_sw = 16'h1234; repeat (3) step();
    t_ir = 1; t_addr = 32'hFFFFFC10; step();
    #2; chk("blk_stall", {31'b0, bus.stall}, 32'h1);
    t_btn = 1; repeat (2) step();
    t_btn = 0; repeat (8) step();
    #2; chk("glitch_stall", {31'b0, bus.stall}, 32'h1);
    chk("glitch_btn_db", 32'(dut.btn_db), 32'h0);
    t_btn = 1; repeat (10) step();
    t_btn = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (phase == 3) begin
        #2; chk("done_stall", {31'b0, bus.stall}, 32'h0);
        chk("done_rdata", bus.rdata, 32'h00001234);
        done = 1;
      end
    end
    chk("done_reached", {31'b0, done}, 32'h1);
    idle(); step();
    #2; chk("idle_after", {31'b0, bus.stall}, 32'h0);

    // reset mid-read
    t_iw = 1; t_addr = 32'hFFFFFC00; t_wdata = 32'hFFFF; step();
    idle(); t_ir = 1; t_addr = 32'hFFFFFC10; t_btn = 1;
    for (int i = 0; i < 20 && phase != 2; i++) step();
    chk("reached_release", phase, 2);
    idle(); t_rst = 1; step();
    t_rst = 0;
    #2; chk("rst_stall", {31'b0, bus.stall}, 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_seg", seg_value, 32'h0);
    t_ir = 1; t_addr = 32'hFFFFFC10; t_sw = 16'hBEEF;
    repeat (12) step();
    t_btn = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (phase == 3) done = 1;
    end
    chk("fresh_done", {31'b0, done}, 32'h1);

    // randomized traffic
    idle(); step();
    for (int n = 0; n < 2000; n++) begin
      t_rst = ($urandom_range(0, 299) == 0);
      t_mr  = ($urandom_range(0, 3) == 0);
      t_mw  = ($urandom_range(0, 3) == 0);
      t_ir  = ($urandom_range(0, 2) == 0);
      t_iw  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 6))
        0: roff = 10'h000;
        1: roff = 10'h004;
        2: roff = 10'h010;
        3: roff = 10'h014;
        4: roff = 10'h018;
        5: roff = 10'h3FC;
        default: roff = 10'($urandom);
      endcase
      t_addr  = (t_ir || t_iw) ? {22'h3FFFFF, roff} : $urandom;
      t_wdata = $urandom;
      t_mrd   = $urandom;
      if ($urandom_range(0, 15) == 0) t_sw = LW'($urandom);
      if ($urandom_range(0, 5) == 0)  t_btn = ~t_btn;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
